// File: rtl/pcm_serial_tx.sv
// PCM serial transmitter: FIFO-buffered samples sent MSB-first with a frame-sync strobe.
// Optional even-parity bit after the LSB when PCM_SERIAL_TX_PARITY_EN is defined.
module pcm_serial_tx #(
    parameter int WIDTH_P    = 24,
    parameter int DEPTH_P    = 4,
    parameter int GAP_P      = 7,
    parameter int FREE_RUN_P = 0
) (
    input  logic                       clk_48kHz,
    input  logic                       rst_n,
    input  logic [WIDTH_P-1:0]         sample_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic                       sdata_o,
    output logic                       fsync_o,
    output logic                       busy_o,
    output logic                       underflow_o,
    output logic [$clog2(DEPTH_P):0]   level_o
);

    localparam int AW      = $clog2(DEPTH_P);
    localparam int LW      = AW + 1;
    localparam int CNT_MAX = (WIDTH_P > GAP_P) ? WIDTH_P : GAP_P;
    localparam int CW      = $clog2(CNT_MAX);

`ifdef PCM_SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, SYNC, SHIFT, PAR, GAP} state_e;
`else
    typedef enum logic [2:0] {IDLE, SYNC, SHIFT, GAP} state_e;
`endif

    state_e               state_q, state_d;
    logic [WIDTH_P-1:0]   mem_q [DEPTH_P];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        count_q, count_d;
    logic [WIDTH_P-1:0]   shift_q, shift_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sdata_q, sdata_d;
    logic                 fsync_q, fsync_d;
    logic                 underflow_q, underflow_d;
`ifdef PCM_SERIAL_TX_PARITY_EN
    logic                 par_q, par_d;
`endif
    logic                 push, pop, frame_end, full, empty;

    // ready_o looks only at registered occupancy, so a same-cycle pop never frees a slot early.
    assign full    = (count_q == LW'(DEPTH_P));
    assign empty   = (count_q == '0);
    assign ready_o = !full;
    assign push    = valid_i && !full;

    // NOTE: sample storage is deliberately not reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk_48kHz) begin
        if (push) mem_q[wr_ptr_q] <= sample_i;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        underflow_d = 1'b0;
        pop         = 1'b0;
        frame_end   = 1'b0;
`ifdef PCM_SERIAL_TX_PARITY_EN
        par_d       = par_q;
`endif
        unique case (state_q)
            IDLE:  frame_end = (FREE_RUN_P != 0) || !empty;
            SYNC: begin
                state_d = SHIFT;
                cnt_d   = CW'(WIDTH_P - 1);
            end
            SHIFT: begin
                shift_d = shift_q << 1;
                if (cnt_q == '0) begin
`ifdef PCM_SERIAL_TX_PARITY_EN
                    state_d = PAR;
`else
                    if (GAP_P > 0) begin
                        state_d = GAP;
                        cnt_d   = CW'(GAP_P - 1);
                    end else begin
                        frame_end = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef PCM_SERIAL_TX_PARITY_EN
            PAR: begin
                if (GAP_P > 0) begin
                    state_d = GAP;
                    cnt_d   = CW'(GAP_P - 1);
                end else begin
                    frame_end = 1'b1;
                end
            end
`endif
            GAP: begin
                if (cnt_q == '0) frame_end = 1'b1;
                else             cnt_d     = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase

        // Frame end: next queued sample, a zero frame when free-running, or idle.
        if (frame_end) begin
            if (!empty) begin
                pop     = 1'b1;
                shift_d = mem_q[rd_ptr_q];
                state_d = SYNC;
            end else if (FREE_RUN_P != 0) begin
                shift_d     = '0;
                underflow_d = 1'b1;
                state_d     = SYNC;
            end else begin
                state_d = IDLE;
            end
`ifdef PCM_SERIAL_TX_PARITY_EN
            par_d = ^shift_d;
`endif
        end

        fsync_d = (state_d == SYNC);
        sdata_d = (state_d == SHIFT) ? shift_d[WIDTH_P-1] : 1'b0;
`ifdef PCM_SERIAL_TX_PARITY_EN
        if (state_d == PAR) sdata_d = par_d;
`endif
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + LW'(push) - LW'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_48kHz) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sdata_q     <= 1'b0;
            fsync_q     <= 1'b0;
            underflow_q <= 1'b0;
`ifdef PCM_SERIAL_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            sdata_q     <= sdata_d;
            fsync_q     <= fsync_d;
            underflow_q <= underflow_d;
`ifdef PCM_SERIAL_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign sdata_o     = sdata_q;
    assign fsync_o     = fsync_q;
    assign busy_o      = (state_q != IDLE);
    assign underflow_o = underflow_q;
    assign level_o     = count_q;

endmodule

// File: tb/tb_pcm_serial_tx.sv
// Bench for pcm_serial_tx: dut0 stops when empty, dut1 free-runs; both checked against a frame-level model.
`timescale 1ns/1ps
module tb_pcm_serial_tx;

    localparam int W     = 24;
    localparam int DEPTH = 4;
    localparam int GAP   = 7;
`ifdef PCM_SERIAL_TX_PARITY_EN
    localparam int PAR   = 1;
`else
    localparam int PAR   = 0;
`endif
    localparam int FL    = 1 + W + GAP + PAR;

    logic           clk_48kHz = 1'b0;
    logic           rst_n;
    logic [1:0]     vld;
    logic [W-1:0]   smp0, smp1;
    logic [1:0]     rdy, sd, fs, bsy, uf;
    logic [2:0]     lvl0, lvl1;
    int             n_assert, n_fail;

    always #5 clk_48kHz = ~clk_48kHz;

    pcm_serial_tx #(.WIDTH_P(W), .DEPTH_P(DEPTH), .GAP_P(GAP), .FREE_RUN_P(0)) dut0 (
        .clk_48kHz(clk_48kHz), .rst_n(rst_n), .sample_i(smp0), .valid_i(vld[0]),
        .ready_o(rdy[0]), .sdata_o(sd[0]), .fsync_o(fs[0]), .busy_o(bsy[0]),
        .underflow_o(uf[0]), .level_o(lvl0));

    pcm_serial_tx #(.WIDTH_P(W), .DEPTH_P(DEPTH), .GAP_P(GAP), .FREE_RUN_P(1)) dut1 (
        .clk_48kHz(clk_48kHz), .rst_n(rst_n), .sample_i(smp1), .valid_i(vld[1]),
        .ready_o(rdy[1]), .sdata_o(sd[1]), .fsync_o(fs[1]), .busy_o(bsy[1]),
        .underflow_o(uf[1]), .level_o(lvl1));

    // Reference model: a sample queue plus a position within the current frame.
    logic [W-1:0] m_mem [2][DEPTH];
    logic [W-1:0] m_cur [2];
    int           m_cnt [2];
    int           m_pos [2];
    bit           m_act [2];
    bit           m_uf  [2];
    bit           mdl_acc, mdl_fe, mdl_v;
    logic [W-1:0] mdl_s;

    always @(posedge clk_48kHz) begin
        for (int d = 0; d < 2; d++) begin
            mdl_v = (d == 0) ? vld[0] : vld[1];
            mdl_s = (d == 0) ? smp0 : smp1;
            if (!rst_n) begin
                m_cnt[d] = 0; m_pos[d] = 0; m_act[d] = 0; m_uf[d] = 0; m_cur[d] = '0;
            end else begin
                mdl_acc  = mdl_v && (m_cnt[d] < DEPTH);
                mdl_fe   = !m_act[d] || (m_pos[d] == FL - 1);
                m_uf[d]  = 0;
                m_pos[d] = m_pos[d] + 1;
                if (mdl_fe) begin
                    m_pos[d] = 0;
                    if (m_cnt[d] > 0) begin
                        m_cur[d] = m_mem[d][0];
                        for (int k = 0; k < DEPTH - 1; k++) m_mem[d][k] = m_mem[d][k+1];
                        m_cnt[d] = m_cnt[d] - 1;
                        m_act[d] = 1;
                    end else if (d == 1) begin
                        m_cur[d] = '0; m_uf[d] = 1; m_act[d] = 1;
                    end else begin
                        m_act[d] = 0;
                    end
                end
                if (mdl_acc) begin
                    m_mem[d][m_cnt[d]] = mdl_s;
                    m_cnt[d] = m_cnt[d] + 1;
                end
            end
        end
    end

    // {fsync, sdata, busy, ready, underflow, level}
    function automatic logic [7:0] exp_vec(input int d);
        logic e_sd;
        e_sd = 1'b0;
        if (m_act[d] && m_pos[d] >= 1 && m_pos[d] <= W) e_sd = m_cur[d][W - m_pos[d]];
        if (PAR == 1 && m_act[d] && m_pos[d] == W + 1) e_sd = ^m_cur[d];
        return {m_act[d] && (m_pos[d] == 0), e_sd, m_act[d], m_cnt[d] < DEPTH, m_uf[d], 3'(m_cnt[d])};
    endfunction

    function automatic logic [7:0] obs_vec(input int d);
        if (d == 0) return {fs[0], sd[0], bsy[0], rdy[0], uf[0], lvl0};
        return {fs[1], sd[1], bsy[1], rdy[1], uf[1], lvl1};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk_48kHz);
        @(negedge clk_48kHz);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_48kHz);
            n_assert++;
            if (obs_vec(0) !== 8'b0001_0000) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %b want %b", i, obs_vec(0), 8'b0001_0000);
            end
        end
    endtask

    task automatic test_single();
        logic [W-1:0] pat;
        pat = 24'b1010_0101_0000_1111_0011_1100;
        @(negedge clk_48kHz); smp0 = 24'hA50F3C; vld[0] = 1'b1;
        @(negedge clk_48kHz); vld[0] = 1'b0;
        @(negedge clk_48kHz);
        n_assert++;
        if (fs[0] !== 1'b1) begin n_fail++; $display("FAIL single_fsync: got %b want 1", fs[0]); end
        for (int i = 0; i < W; i++) begin
            @(negedge clk_48kHz);
            n_assert++;
            if (sd[0] !== pat[W-1-i]) begin
                n_fail++; $display("FAIL single_bit %0d: got %b want %b", i, sd[0], pat[W-1-i]);
            end
        end
`ifdef PCM_SERIAL_TX_PARITY_EN
        @(negedge clk_48kHz);
        n_assert++;
        if (sd[0] !== ^pat) begin n_fail++; $display("FAIL single_parity: got %b want %b", sd[0], ^pat); end
`endif
        for (int i = 0; i < GAP; i++) begin
            @(negedge clk_48kHz);
            n_assert++;
            if ({sd[0], bsy[0]} !== 2'b01) begin
                n_fail++; $display("FAIL single_gap %0d: sdata,busy got %b%b want 01", i, sd[0], bsy[0]);
            end
        end
        @(negedge clk_48kHz);
        n_assert++;
        if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b want 0", bsy[0]); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] list [8];
        logic [W-1:0] word;
        int idx, nfr, last_fs, cap;
        bit done, seen_not_ready;
        list[0] = 24'h800000; list[1] = 24'h7FFFFF; list[2] = 24'h000001;
        list[3] = 24'hFFFFFF; list[4] = 24'h123456;
        for (int k = 5; k < 8; k++) list[k] = W'($urandom);
        idx = 0; nfr = 0; last_fs = -1; cap = -1; done = 0; seen_not_ready = 0; word = '0;
        for (int cyc = 0; cyc < 1500 && !done; cyc++) begin
            @(negedge clk_48kHz);
            n_assert++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++; $display("FAIL b2b_cycle %0d: got %b want %b", cyc, obs_vec(0), exp_vec(0));
            end
            if (cap >= 0 && cap < W) begin
                word = {word[W-2:0], sd[0]};
                cap++;
                if (cap == W && nfr < 8) begin
                    n_assert++;
                    if (word !== list[nfr]) begin
                        n_fail++; $display("FAIL b2b_frame %0d: got %h want %h", nfr, word, list[nfr]);
                    end
                    nfr++;
                end
            end
            if (fs[0] === 1'b1) begin
                if (last_fs >= 0) begin
                    n_assert++;
                    if (cyc - last_fs != FL) begin
                        n_fail++; $display("FAIL b2b_period: got %0d want %0d", cyc - last_fs, FL);
                    end
                end
                last_fs = cyc; cap = 0;
            end
            if (lvl0 === 3'd4) begin
                n_assert++;
                if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %b want 0", rdy[0]); end
            end
            if (rdy[0] === 1'b0) seen_not_ready = 1;
            if (idx < 8) begin
                vld[0] = 1'b1; smp0 = list[idx];
                if (m_cnt[0] < DEPTH) idx++;
            end else begin
                vld[0] = 1'b0;
                if (!m_act[0] && m_cnt[0] == 0 && cyc > 40) done = 1;
            end
        end
        vld[0] = 1'b0;
        n_assert++;
        if (!done) begin n_fail++; $display("FAIL b2b_timeout: got not idle want idle"); end
        n_assert++;
        if (nfr != 8) begin n_fail++; $display("FAIL b2b_frame_count: got %0d want 8", nfr); end
        n_assert++;
        if (!seen_not_ready) begin n_fail++; $display("FAIL b2b_blocked: ready never low, want low while full"); end
    endtask

    task automatic test_underflow();
        logic [W-1:0] word;
        int last_fs, cap;
        bit uf_at, prev_smp, seen_smp;
        last_fs = -1; cap = -1; uf_at = 0; prev_smp = 0; seen_smp = 0; word = '0;
        for (int cyc = 0; cyc < 6 * FL; cyc++) begin
            @(negedge clk_48kHz);
            n_assert++;
            if (obs_vec(1) !== exp_vec(1)) begin
                n_fail++; $display("FAIL uf_cycle %0d: got %b want %b", cyc, obs_vec(1), exp_vec(1));
            end
            if (cap >= 0 && cap < W) begin
                word = {word[W-2:0], sd[1]};
                cap++;
                if (cap == W) begin
                    n_assert++;
                    if (uf_at !== (word == '0)) begin
                        n_fail++; $display("FAIL uf_vs_zero_frame: underflow %b for frame %h", uf_at, word);
                    end
                    if (prev_smp) begin
                        n_assert++;
                        if (word !== '0) begin n_fail++; $display("FAIL uf_zero_after_sample: got %h want 0", word); end
                    end
                    prev_smp = (word == 24'h00FF00);
                    if (prev_smp) seen_smp = 1;
                end
            end
            if (uf[1] === 1'b1) begin
                n_assert++;
                if (fs[1] !== 1'b1) begin n_fail++; $display("FAIL uf_outside_sync: fsync %b want 1", fs[1]); end
            end
            if (fs[1] === 1'b1) begin
                if (last_fs >= 0) begin
                    n_assert++;
                    if (cyc - last_fs != FL) begin
                        n_fail++; $display("FAIL uf_period: got %0d want %0d", cyc - last_fs, FL);
                    end
                end
                last_fs = cyc; cap = 0; uf_at = uf[1];
            end
            vld[1] = (cyc == 0);
            smp1   = 24'h00FF00;
        end
        vld[1] = 1'b0;
        n_assert++;
        if (!seen_smp) begin n_fail++; $display("FAIL uf_sample_frame: 00ff00 frame not seen"); end
    endtask

    task automatic test_random();
        bit done;
        for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge clk_48kHz);
            for (int d = 0; d < 2; d++) begin
                n_assert++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    n_fail++; $display("FAIL rand_dut%0d cyc %0d: got %b want %b", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            vld[0] = ($urandom_range(0, 9) < 2); smp0 = W'($urandom);
            vld[1] = ($urandom_range(0, 9) < 2); smp1 = W'($urandom);
        end
        vld = 2'b00;
        done = 0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk_48kHz);
            n_assert++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++; $display("FAIL rand_drain cyc %0d: got %b want %b", cyc, obs_vec(0), exp_vec(0));
            end
            if (!m_act[0] && m_cnt[0] == 0) done = 1;
        end
        n_assert++;
        if (!done) begin n_fail++; $display("FAIL rand_drain_timeout: got busy want idle"); end
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk_48kHz);
            if (i < 3) begin vld[0] = 1'b1; smp0 = W'($urandom); end
            else vld[0] = 1'b0;
            if (fs[0] === 1'b1) found = 1;
        end
        n_assert++;
        if (!found) begin n_fail++; $display("FAIL midrst_fsync_timeout: no fsync seen"); end
        @(negedge clk_48kHz); vld[0] = 1'b0;
        repeat (10) @(negedge clk_48kHz);
        n_assert++;
        if (lvl0 !== 3'd2) begin n_fail++; $display("FAIL midrst_queued: got %0d want 2", lvl0); end
        rst_n = 1'b0;
        @(negedge clk_48kHz);
        n_assert++;
        if ({sd[0], fs[0], lvl0} !== 5'b0) begin
            n_fail++; $display("FAIL midrst_abort: sdata,fsync,level got %b want 00000", {sd[0], fs[0], lvl0});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3 * FL; i++) begin
            @(negedge clk_48kHz);
            n_assert++;
            if ({fs[0], bsy[0], sd[0]} !== 3'b000) begin
                n_fail++; $display("FAIL midrst_no_resume cyc %0d: fsync,busy,sdata got %b want 000", i, {fs[0], bsy[0], sd[0]});
            end
        end
    endtask

`ifdef PCM_SERIAL_TX_PARITY_EN
    task automatic test_parity();
        bit found;
        int t0;
        found = 0; t0 = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk_48kHz);
            if (i < 2) begin vld[0] = 1'b1; smp0 = 24'h000007; end
            else vld[0] = 1'b0;
            if (fs[0] === 1'b1) found = 1;
        end
        n_assert++;
        if (!found) begin n_fail++; $display("FAIL parity_fsync_timeout: no fsync seen"); end
        @(negedge clk_48kHz); vld[0] = 1'b0;
        repeat (W - 1) @(negedge clk_48kHz);
        @(negedge clk_48kHz);
        n_assert++;
        if (sd[0] !== 1'b1) begin n_fail++; $display("FAIL parity_bit: got %b want 1", sd[0]); end
        for (int i = 0; i < GAP; i++) begin
            @(negedge clk_48kHz);
            n_assert++;
            if (sd[0] !== 1'b0) begin n_fail++; $display("FAIL parity_gap %0d: got %b want 0", i, sd[0]); end
        end
        @(negedge clk_48kHz);
        n_assert++;
        if (fs[0] !== 1'b1) begin n_fail++; $display("FAIL parity_period: fsync got %b want 1 at 33", fs[0]); end
        repeat (FL + 2) @(negedge clk_48kHz);
    endtask
`endif

    initial begin
        n_assert = 0; n_fail = 0;
        rst_n = 1'b0; vld = 2'b00; smp0 = '0; smp1 = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_underflow();
        test_random();
        test_mid_reset();
`ifdef PCM_SERIAL_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
